md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in EX beside the combinational ALU and serves mult, multu, div, divu, mthi and mtlo.
- Parametrised in data width and in per-class latency.
- Exposes `busy` so the hazard unit can stall any HI/LO-touching instruction in D while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be at least 2.
- MUL_LAT, 5, cycles for which `busy` stays high after a mult/multu start; must be at least 1.
- DIV_LAT, 10, cycles for which `busy` stays high after a div/divu start; must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; `op`, `A` and `B` are sampled on the same edge.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  WIDTH  rs operand: multiplicand, dividend, or mthi/mtlo source.
- B  input  WIDTH  rt operand: multiplier or divisor.
- busy  output  1  operation in flight.
- hi  output  WIDTH  HI register, read by mfhi.
- lo  output  WIDTH  LO register, read by mflo.

Behaviour:
- Reset: on a rising edge with `reset`=1, set hi=0, lo=0, busy=0 and counter=0, and discard any pending result.
  - Reset wins over a simultaneous `start`.
  - Reset mid-operation aborts the operation; no partial write to HI/LO.
- Accept condition: `start`=1 and busy=0 and op in 1..6. Otherwise `start` is ignored.
  - A start while busy is dropped, not queued; the hazard unit guarantees this never happens in the pipeline.
- mthi/mtlo:
  - hi (resp. lo) takes A on the accepting edge.
  - `busy` stays 0.
  - The other register is unchanged.
- mult/multu/div/divu on the accepting edge:
  - Compute the result from the sampled A and B into pending registers `phi`/`plo`.
  - Load the counter with MUL_LAT or DIV_LAT.
  - Later changes on A and B have no effect.
- Busy and counter:
  - `busy` is registered and equals (counter != 0).
  - The counter decrements by 1 each cycle while nonzero.
  - On the edge where the counter goes 1 -> 0, hi<=phi and lo<=plo, and busy falls on that same edge.
  - Net timing: start sampled at edge E0; busy high for exactly LAT cycles after E0; new hi/lo visible from edge E0+LAT onward.
  - hi and lo keep their old values throughout the busy window.
- mult: signed(A) * signed(B), full 2*WIDTH result; hi = upper WIDTH bits, lo = lower WIDTH bits.
- multu: same as mult with both operands unsigned.
- divu: lo = A / B, hi = A % B, unsigned.
- div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Example: -7 div 2 gives lo=-3, hi=-1.
  - Overflow case A = -2^(WIDTH-1), B = -1: lo = -2^(WIDTH-1), hi = 0, with no exception.
- Divide by zero (div or divu with B=0):
  - The operation is accepted and busy runs the full DIV_LAT.
  - HI and LO are left unchanged at completion.
- Back-to-back operation: a new start is accepted on the same edge where busy is already 0, i.e. the cycle after completion. There is no bubble beyond that.
- No combinational path from any input to `busy`, `hi` or `lo`; all three are register outputs.

Test Plan:
- Reset, then mthi A=0x12345678 and mtlo A=0xCAFEBABE in consecutive cycles -> hi=0x12345678, lo=0xCAFEBABE; busy never rises.
- mult with A=0xFFFFFFFF (-1) and B=0x00000003 -> busy high exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFD after busy falls; multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFD.
- div with A=0xFFFFFFF9 (-7) and B=2 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; div with A=0x80000000 and B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22, then divu with B=0 -> busy for 10 cycles; hi=0x11, lo=0x22 unchanged. Issue a second start with op=mult during busy -> ignored, result unaffected.
- Start mult, assert reset on the 3rd busy cycle -> next edge busy=0, hi=lo=0, and no later write occurs. Also drive A/B randomly during a busy window -> the result uses only the operands sampled at start.
- Parametrised build with WIDTH=16, MUL_LAT=1, DIV_LAT=1: multu 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001 one edge after start, busy high for 1 cycle. Back-to-back accepted start the following cycle.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the architectural HI/LO
// registers. Results are computed on the accepting edge into pending
// registers and committed to HI/LO when the latency counter expires, so the
// pipeline sees the same timing as a real iterative multiplier/divider.
module md_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // Architectural and pending state.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_phi;
    logic [WIDTH-1:0] r_plo;
    logic             r_pwrite;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    op_e              w_op;
    logic             w_accept;
    logic             w_b_zero;

    // Multiplier products, full double width.
    logic signed [2*WIDTH-1:0] w_prod_s;
    logic        [2*WIDTH-1:0] w_prod_u;

    // Divider datapath. The divisor is forced to 1 on divide-by-zero so the
    // operators never see zero; that result is discarded anyway.
    logic [WIDTH-1:0] w_b_safe;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_sq_mag;
    logic [WIDTH-1:0] w_sr_mag;
    logic [WIDTH-1:0] w_sq;
    logic [WIDTH-1:0] w_sr;
    logic [WIDTH-1:0] w_uq;
    logic [WIDTH-1:0] w_ur;

    // Result selected for the pending registers.
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic [CNT_W-1:0] w_lat;
    logic             w_res_write;

    assign w_op     = op_e'(op);
    assign w_accept = start && !r_busy && (w_op != OP_NONE) && (w_op != OP_RSVD);
    assign w_b_zero = (B == '0);

    assign w_prod_s = $signed(A) * $signed(B);
    assign w_prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    // Signed divide is done on magnitudes: this makes truncation toward zero
    // explicit and handles -2^(WIDTH-1) / -1 without relying on overflow
    // behaviour of a signed divide operator (the quotient magnitude wraps
    // back to -2^(WIDTH-1), remainder 0).
    assign w_b_safe = w_b_zero ? WIDTH'(1) : B;
    assign w_a_mag  = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    assign w_b_mag  = B[WIDTH-1] ? (~B + WIDTH'(1)) : w_b_safe;
    assign w_sq_mag = w_a_mag / w_b_mag;
    assign w_sr_mag = w_a_mag % w_b_mag;
    assign w_sq     = (A[WIDTH-1] ^ B[WIDTH-1]) ? (~w_sq_mag + WIDTH'(1)) : w_sq_mag;
    assign w_sr     = A[WIDTH-1] ? (~w_sr_mag + WIDTH'(1)) : w_sr_mag;
    assign w_uq     = A / w_b_safe;
    assign w_ur     = A % w_b_safe;

    // Select the result, latency and commit flag for the requested op.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        w_res_hi    = '0;
        w_res_lo    = '0;
        w_lat       = '0;
        w_res_write = 1'b0;
        unique case (w_op)
            OP_MULT: begin
                w_res_hi    = w_prod_s[2*WIDTH-1:WIDTH];
                w_res_lo    = w_prod_s[WIDTH-1:0];
                w_lat       = CNT_W'(MUL_LAT);
                w_res_write = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi    = w_prod_u[2*WIDTH-1:WIDTH];
                w_res_lo    = w_prod_u[WIDTH-1:0];
                w_lat       = CNT_W'(MUL_LAT);
                w_res_write = 1'b1;
            end
            OP_DIV: begin
                w_res_hi    = w_sr;
                w_res_lo    = w_sq;
                w_lat       = CNT_W'(DIV_LAT);
                w_res_write = !w_b_zero;
            end
            OP_DIVU: begin
                w_res_hi    = w_ur;
                w_res_lo    = w_uq;
                w_lat       = CNT_W'(DIV_LAT);
                w_res_write = !w_b_zero;
            end
            default: begin
                w_res_hi    = '0;
                w_res_lo    = '0;
                w_lat       = '0;
                w_res_write = 1'b0;
            end
        endcase
    end

    // Accept requests, run the latency counter, commit results to HI/LO.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_phi    <= '0;
            r_plo    <= '0;
            r_pwrite <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (w_accept) begin
            if (w_op == OP_MTHI) begin
                r_hi <= A;
            end else if (w_op == OP_MTLO) begin
                r_lo <= A;
            end else begin
                r_phi    <= w_res_hi;
                r_plo    <= w_res_lo;
                r_pwrite <= w_res_write;
                r_cnt    <= w_lat;
                r_busy   <= 1'b1;
            end
        end else if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_busy <= (r_cnt != CNT_W'(1));
            if ((r_cnt == CNT_W'(1)) && r_pwrite) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: table-driven operations on a 32-bit instance with a
// scoreboard queue of expected HI/LO, plus hand-written sequences for
// mid-operation reset and a 16-bit single-cycle-latency instance.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;

    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        s_start;
    logic [2:0]  s_op;
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic        s_busy;
    logic [15:0] s_hi;
    logic [15:0] s_lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        bit          inject;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    md_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    md_unit #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(1)) dut16 (
        .clk   (clk),
        .reset (reset),
        .start (s_start),
        .op    (s_op),
        .A     (s_a),
        .B     (s_b),
        .busy  (s_busy),
        .hi    (s_hi),
        .lo    (s_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request and follow it to completion. Inputs are scrambled
    // during the busy window; HI/LO must hold their old value until the end.
    task automatic run_op(input string name, input logic [2:0] op_i,
                          input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int lat, input bit inject);
        int   n;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = op_i;
        A     = a_i;
        B     = b_i;
        exp_q.push_back('{hi: exp_hi, lo: exp_lo});
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        A     = $urandom;
        B     = $urandom;
        n     = 0;
        while (busy && n < 100) begin
            n++;
            check({name, " hold"}, {hi, lo}, {cur_hi, cur_lo});
            if (inject && n == 2) begin
                start = 1'b1;
                op    = 3'd1;
            end else begin
                start = 1'b0;
                op    = 3'd0;
            end
            A = $urandom;
            B = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        op    = 3'd0;
        check({name, " busy_cycles"}, 64'(n), 64'(lat));
        e = exp_q.pop_front();
        check({name, " hi"}, 64'(hi), 64'(e.hi));
        check({name, " lo"}, 64'(lo), 64'(e.lo));
        cur_hi = e.hi;
        cur_lo = e.lo;
    endtask

    vec_t vecs[14];

    initial begin
        logic signed [63:0] ps;
        logic        [63:0] pu;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic        [31:0] ra;
        logic        [31:0] rb;

        vecs[0]  = '{3'd5, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0,  1'b0}; // mthi
        vecs[1]  = '{3'd6, 32'hCAFEBABE, 32'h0,        32'h12345678, 32'hCAFEBABE, 0,  1'b0}; // mtlo
        vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFD, 5,  1'b0}; // mult -1*3
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'h3,        32'h00000002, 32'hFFFFFFFD, 5,  1'b0}; // multu
        vecs[4]  = '{3'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0}; // -7 div 2
        vecs[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0}; // overflow
        vecs[6]  = '{3'd5, 32'h00000011, 32'h0,        32'h00000011, 32'h80000000, 0,  1'b0}; // mthi
        vecs[7]  = '{3'd6, 32'h00000022, 32'h0,        32'h00000011, 32'h00000022, 0,  1'b0}; // mtlo
        vecs[8]  = '{3'd4, 32'h00001234, 32'h0,        32'h00000011, 32'h00000022, 10, 1'b1}; // divu by 0
        vecs[9]  = '{3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10, 1'b0}; // divu
        vecs[10] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 1'b0}; // 7 div -2
        vecs[11] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5,  1'b0}; // max*max
        vecs[12] = '{3'd0, 32'hDEADBEEF, 32'h1,        32'h3FFFFFFF, 32'h00000001, 0,  1'b0}; // none
        vecs[13] = '{3'd7, 32'hDEADBEEF, 32'h1,        32'h3FFFFFFF, 32'h00000001, 0,  1'b0}; // reserved

        reset   = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        A       = '0;
        B       = '0;
        s_start = 1'b0;
        s_op    = 3'd0;
        s_a     = '0;
        s_b     = '0;
        cur_hi  = '0;
        cur_lo  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        check("reset16 busy", 64'(s_busy), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].lat, vecs[i].inject);
        end

        // Randomised operands against a simple reference model.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 4)
                0: begin
                    ps = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
                    run_op($sformatf("rnd_mult%0d", i), 3'd1, ra, rb, ps[63:32], ps[31:0], 5, 1'b0);
                end
                1: begin
                    pu = {32'b0, ra} * {32'b0, rb};
                    run_op($sformatf("rnd_multu%0d", i), 3'd2, ra, rb, pu[63:32], pu[31:0], 5, 1'b0);
                end
                2: begin
                    rb = $urandom_range(1, 1000);
                    run_op($sformatf("rnd_divu%0d", i), 3'd4, ra, rb, ra % rb, ra / rb, 10, 1'b0);
                end
                default: begin
                    sbv = $urandom_range(1, 200);
                    if ($urandom_range(0, 1) == 1) sbv = -sbv;
                    sa  = $signed(ra);
                    run_op($sformatf("rnd_div%0d", i), 3'd3, ra, sbv, sa % sbv, sa / sbv, 10, 1'b0);
                end
            endcase
        end

        // Reset in the third busy cycle of a mult aborts it cleanly.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd1;
        A     = 32'd5;
        B     = 32'd6;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        check("abort busy1", 64'(busy), 64'(1));
        @(negedge clk);
        @(negedge clk);
        check("abort busy3", 64'(busy), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'(0));
        check("abort hi", 64'(hi), 64'(0));
        check("abort lo", 64'(lo), 64'(0));
        repeat (12) @(negedge clk);
        check("abort late hi", 64'(hi), 64'(0));
        check("abort late lo", 64'(lo), 64'(0));
        check("abort late busy", 64'(busy), 64'(0));

        // 16-bit, latency 1: multu then a back-to-back mult.
        @(negedge clk);
        s_start = 1'b1;
        s_op    = 3'd2;
        s_a     = 16'hFFFF;
        s_b     = 16'hFFFF;
        @(negedge clk);
        s_start = 1'b0;
        s_op    = 3'd0;
        s_a     = 16'h1357;
        s_b     = 16'h2468;
        check("w16 busy", 64'(s_busy), 64'(1));
        check("w16 hold hi", 64'(s_hi), 64'(0));
        @(negedge clk);
        check("w16 done busy", 64'(s_busy), 64'(0));
        check("w16 multu hi", 64'(s_hi), 64'(16'hFFFE));
        check("w16 multu lo", 64'(s_lo), 64'(16'h0001));
        s_start = 1'b1;
        s_op    = 3'd1;
        s_a     = 16'h0003;
        s_b     = 16'hFFFE;
        @(negedge clk);
        s_start = 1'b0;
        s_op    = 3'd0;
        check("w16 b2b busy", 64'(s_busy), 64'(1));
        @(negedge clk);
        check("w16 b2b done", 64'(s_busy), 64'(0));
        check("w16 mult hi", 64'(s_hi), 64'(16'hFFFF));
        check("w16 mult lo", 64'(s_lo), 64'(16'hFFFA));

        check("scoreboard empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so a stuck DUT still ends with a summary.
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: simulation did not complete, got running expected done");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
